// File: rtl/spi_peripheral_pkg.sv
// rtl/spi_peripheral_pkg.sv - shared widths, FSM state encodings and helpers for spi_peripheral
package spi_peripheral_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_ADDR_W = 4;

  localparam logic [2:0] SPI_ST_IDLE  = 3'd0;
  localparam logic [2:0] SPI_ST_CMD   = 3'd1;
  localparam logic [2:0] SPI_ST_ADDR  = 3'd2;
  localparam logic [2:0] SPI_ST_WDATA = 3'd3;
  localparam logic [2:0] SPI_ST_RDATA = 3'd4;
  localparam logic [2:0] SPI_ST_DONE  = 3'd5;

  localparam logic SPI_RW_WRITE = 1'b1;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - data memory port driven by the SPI responder
interface spi_peripheral_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr_en_out;
  logic              rd_en_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] wdata_out;
  logic [DATA_W-1:0] rdata_in;

  modport master (
    output wr_en_out,
    output rd_en_out,
    output addr_out,
    output wdata_out,
    input  rdata_in
  );

  modport slave (
    input  wr_en_out,
    input  rd_en_out,
    input  addr_out,
    input  wdata_out,
    output rdata_in
  );
endinterface

// File: rtl/spi_peripheral_sync.sv
// rtl/spi_peripheral_sync.sv - 2-FF synchronizers for SPI pins, edge pulses from a third stage
module spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic cs_n_in,
  input  logic mosi_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_s
);
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_in};
      cs_q   <= {cs_q[1:0], cs_n_in};
      mosi_q <= {mosi_q[0], mosi_in};
    end
  end

  // mosi_s is taken from the same stage as the sclk level so a rise pulse sees the matching bit
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s    = cs_q[1];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];
endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 responder issuing data memory read/write strobes
// Optional word bursts with auto-incrementing address under `define SPI_PERIPH_BURST_EN.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int ADDR_W = SPI_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic cs_n_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic miso_oe_out,
  output logic busy_out,
  spi_peripheral_if.master mem
);
  localparam int MAX_W = spi_max(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(MAX_W) + 1;

  logic sclk_rise, sclk_fall, cs_n_s, cs_rise, cs_fall, mosi_s;

  spi_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .cs_n_in   (cs_n_in),
    .mosi_in   (mosi_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .mosi_s    (mosi_s)
  );

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [MAX_W-2:0]  rx_sr;
  logic [MAX_W-1:0]  rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] wdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] a_field;
  logic              rw;
  logic              armed;
  logic              ld_q;
  logic              miso_r;
  logic              wr_en;
  logic              rd_en;

  assign rx_next = {rx_sr, mosi_s};

  // armed blocks a frame from starting until cs_n has been seen high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SPI_ST_IDLE;
      cnt     <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      wdata_r <= '0;
      addr_r  <= '0;
      a_field <= '0;
      rw      <= 1'b0;
      armed   <= 1'b0;
      ld_q    <= 1'b0;
      miso_r  <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      ld_q  <= rd_en;
      if (cs_n_s) armed <= 1'b1;
      if (ld_q) tx_sr <= mem.rdata_in;
      if (state != SPI_ST_IDLE && cs_rise) begin
        state  <= SPI_ST_IDLE;
        miso_r <= 1'b0;
      end else begin
        case (state)
          SPI_ST_IDLE: begin
            if (cs_fall && armed) begin
              state  <= SPI_ST_CMD;
              miso_r <= 1'b0;
            end
          end
          SPI_ST_CMD: begin
            if (sclk_rise) begin
              rw    <= mosi_s;
              cnt   <= CNT_W'(ADDR_W);
              state <= SPI_ST_ADDR;
            end
          end
          SPI_ST_ADDR: begin
            if (sclk_rise) begin
              rx_sr <= rx_next[MAX_W-2:0];
              cnt   <= cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) begin
                cnt <= CNT_W'(DATA_W);
                if (rw == SPI_RW_WRITE) begin
                  a_field <= rx_next[ADDR_W-1:0];
                  state   <= SPI_ST_WDATA;
                end else begin
                  addr_r  <= rx_next[ADDR_W-1:0];
                  a_field <= rx_next[ADDR_W-1:0] + ADDR_W'(1);
                  rd_en   <= 1'b1;
                  state   <= SPI_ST_RDATA;
                end
              end
            end
          end
          SPI_ST_WDATA: begin
            if (sclk_rise) begin
              rx_sr <= rx_next[MAX_W-2:0];
              cnt   <= cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) begin
                wdata_r <= rx_next[DATA_W-1:0];
                addr_r  <= a_field;
                a_field <= a_field + ADDR_W'(1);
                wr_en   <= 1'b1;
`ifdef SPI_PERIPH_BURST_EN
                cnt     <= CNT_W'(DATA_W);
`else
                state   <= SPI_ST_DONE;
`endif
              end
            end
          end
          SPI_ST_RDATA: begin
            // the last bit stays on miso until the master's sampling rise has been seen
            if (sclk_fall && cnt != '0) begin
              miso_r <= tx_sr[DATA_W-1];
              tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              cnt    <= cnt - CNT_W'(1);
`ifdef SPI_PERIPH_BURST_EN
              if (cnt == CNT_W'(1)) begin
                addr_r  <= a_field;
                a_field <= a_field + ADDR_W'(1);
                rd_en   <= 1'b1;
              end
`endif
            end else if (sclk_rise && cnt == '0) begin
`ifdef SPI_PERIPH_BURST_EN
              cnt   <= CNT_W'(DATA_W);
`else
              state <= SPI_ST_DONE;
`endif
            end
          end
          SPI_ST_DONE: begin
          end
          default: state <= SPI_ST_IDLE;
        endcase
      end
    end
  end

  assign miso_out      = (state == SPI_ST_RDATA) & miso_r;
  assign miso_oe_out   = ~cs_n_s & armed;
  assign busy_out      = (state != SPI_ST_IDLE);
  assign mem.wr_en_out = wr_en;
  assign mem.rd_en_out = rd_en;
  assign mem.addr_out  = addr_r;
  assign mem.wdata_out = wdata_r;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - self-checking bench for spi_peripheral with memory and reference model
module tb_spi_peripheral;
  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi;
  logic miso, oe, busy;
  int   checks = 0;
  int   errors = 0;

  spi_peripheral_if #(.ADDR_W(4), .DATA_W(8)) mem_if ();

  spi_peripheral #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_in     (sclk),
    .cs_n_in     (cs_n),
    .mosi_in     (mosi),
    .miso_out    (miso),
    .miso_oe_out (oe),
    .busy_out    (busy),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];

  always @(posedge clk) begin
    if (mem_if.rd_en_out) mem_if.rdata_in <= mem[mem_if.addr_out];
    if (mem_if.wr_en_out) mem[mem_if.addr_out] <= mem_if.wdata_out;
  end

  always @(negedge clk) begin
    if (mem_if.wr_en_out) wr_q.push_back({mem_if.addr_out, mem_if.wdata_out});
    if (mem_if.rd_en_out) rd_q.push_back(mem_if.addr_out);
  end

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [63:0] bits, input int n, output logic [63:0] cap);
    cap  = '0;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clk(4);
      sclk = 1'b1;
      cap  = {cap[62:0], miso};
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(16);
  endtask

  task automatic run_frame(input logic rw, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
    logic [63:0] cap;
    wr_q.delete();
    rd_q.delete();
    xfer({51'd0, rw, a, d}, 13, cap);
    if (rw) begin
      check("wr_count", 32'(wr_q.size()), 32'd1);
      check("rd_count_on_write", 32'(rd_q.size()), 32'd0);
      if (wr_q.size() == 1) check("wr_addr_data", 32'(wr_q[0]), 32'({a, d}));
      ref_mem[a] = d;
    end else begin
      check("rd_count", 32'(rd_q.size()), 32'd1);
      check("wr_count_on_read", 32'(wr_q.size()), 32'd0);
      if (rd_q.size() == 1) check("rd_addr", 32'(rd_q[0]), 32'(a));
      check("miso_data", 32'(cap[7:0]), 32'(exp_rd));
    end
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] cap;
    logic        got;
    logic        rw;
    logic [3:0]  a;
    logic [7:0]  d;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[2]     = 8'h3C;
    ref_mem[2] = 8'h3C;
    mem_if.rdata_in = 8'h00;

    vecs[0] = '{1'b1, 4'h5, 8'hA3, 8'h00};
    vecs[1] = '{1'b0, 4'h2, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 4'h1, 8'h11, 8'h00};
    vecs[3] = '{1'b0, 4'h1, 8'h00, 8'h11};
    vecs[4] = '{1'b0, 4'h5, 8'h00, 8'hA3};
    vecs[5] = '{1'b1, 4'hF, 8'h5A, 8'h00};
    vecs[6] = '{1'b0, 4'hF, 8'h00, 8'h5A};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(5);
    check("reset_outputs", 32'({miso, oe, mem_if.wr_en_out, mem_if.rd_en_out,
                                mem_if.addr_out, mem_if.wdata_out, busy}), 32'd0);
    rst = 1'b0;
    wait_clk(8);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);

    // abort a write after three data bits, then confirm the target is untouched
    wr_q.delete();
    xfer({56'd0, 1'b1, 4'h3, 3'b101}, 8, cap);
    check("abort_no_strobe", 32'(wr_q.size()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    run_frame(1'b0, 4'h3, 8'h00, ref_mem[3]);

    // reset right after the read strobe, with cs_n still held low
    rd_q.delete();
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 4; i >= 0; i--) begin
      mosi = 5'b00101 >> i;
      wait_clk(4);
      sclk = 1'b1;
      if (i != 0) begin
        wait_clk(4);
        sclk = 1'b0;
      end
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = mem_if.rd_en_out;
    end
    check("rd_strobe_before_reset", 32'(got), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs", 32'({miso, oe, mem_if.wr_en_out, mem_if.rd_en_out,
                                         mem_if.addr_out, mem_if.wdata_out, busy}), 32'd0);
    rst = 1'b0;
    wait_clk(2);
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < 8; i++) begin
      wait_clk(4);
      sclk = ~sclk;
      wait_clk(4);
      sclk = ~sclk;
    end
    check("post_reset_strobes", 32'(wr_q.size() + rd_q.size()), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_oe", 32'(oe), 32'd0);
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clk(16);
    run_frame(1'b0, 4'h5, 8'h00, ref_mem[5]);

    // two-word write and read starting at the top address
    wr_q.delete();
    rd_q.delete();
    xfer({43'd0, 1'b1, 4'hF, 8'h01, 8'h02}, 21, cap);
`ifdef SPI_PERIPH_BURST_EN
    check("burst_wr_count", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("burst_wr0", 32'(wr_q[0]), 32'h0F01);
      check("burst_wr1", 32'(wr_q[1]), 32'h0002);
    end
    ref_mem[15] = 8'h01;
    ref_mem[0]  = 8'h02;
`else
    check("single_wr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) check("single_wr0", 32'(wr_q[0]), 32'h0F01);
    ref_mem[15] = 8'h01;
`endif
    rd_q.delete();
    wr_q.delete();
    xfer({43'd0, 1'b0, 4'hF, 16'h0000}, 21, cap);
`ifdef SPI_PERIPH_BURST_EN
    check("burst_rd_count", 32'(rd_q.size()), 32'd3);
    if (rd_q.size() == 3) check("burst_rd1_addr", 32'(rd_q[1]), 32'h0);
    check("burst_rd_data", 32'(cap[15:0]), 32'({ref_mem[15], ref_mem[0]}));
`else
    check("single_rd_count", 32'(rd_q.size()), 32'd1);
    check("single_rd_data", 32'(cap[15:0]), 32'({ref_mem[15], 8'h00}));
`endif

    for (int n = 0; n < 30; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      run_frame(rw, a, d, ref_mem[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
